// File: rtl/mips16_pkg.sv
// Shared definitions for the MIPS16 multi-cycle controller: opcodes, FSM states
// and the datapath mux/ALU encodings.
package mips16_pkg;

  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_SLTI  = 3'b001;
  localparam logic [2:0] OP_J     = 3'b010;
  localparam logic [2:0] OP_JAL   = 3'b011;
  localparam logic [2:0] OP_LW    = 3'b100;
  localparam logic [2:0] OP_SW    = 3'b101;
  localparam logic [2:0] OP_BEQ   = 3'b110;
  localparam logic [2:0] OP_ADDI  = 3'b111;

  localparam logic [3:0] FUNCT_JR = 4'b1000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_ERROR
  } state_t;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  localparam logic [1:0] ALUB_RT     = 2'b00;
  localparam logic [1:0] ALUB_TWO    = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_SLT = 2'b10;
  localparam logic [1:0] ALU_IMM = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC  = 2'b10;

endpackage

// File: rtl/mips16_ack_timer.sv
// Counts consecutive cycles spent waiting for a memory ack; expired flags the
// cycle that would be the ACK_TIMEOUT-th one without an ack.
module mips16_ack_timer #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_ON = (ACK_TIMEOUT > 0);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable)
      count <= count + 1'b1;
  end

  assign expired = TIMEOUT_ON && enable && (count == LAST);

endmodule

// File: rtl/mips16_mc_control.sv
// Multi-cycle MIPS16 control FSM. State is registered; strobes are decoded from
// state plus mem_ack/zero so a zero-wait memory completes in the request cycle.
module mips16_mc_control
  import mips16_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [2:0] opcode,
  input  logic [3:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       sign_or_zero,
  output logic       retired,
  output logic       err
);

  state_t state, next_state, done_state;
  logic   waiting, timer_clear, timer_enable, timer_expired;

  assign waiting      = (state == ST_FETCH) || (state == ST_MEM);
  assign timer_enable = waiting && !mem_ack;
  assign timer_clear  = (next_state != state);
  assign done_state   = run ? ST_FETCH : ST_IDLE;

  mips16_ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // An ack always wins over the timeout, even on the threshold cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (run) next_state = ST_FETCH;
      ST_FETCH:  if (mem_ack) next_state = ST_DECODE;
                 else if (timer_expired) next_state = ST_ERROR;
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC: begin
        case (opcode)
          OP_RTYPE:         next_state = (funct == FUNCT_JR) ? done_state : ST_WB;
          OP_SLTI, OP_ADDI: next_state = ST_WB;
          OP_LW, OP_SW:     next_state = ST_MEM;
          default:          next_state = done_state;
        endcase
      end
      ST_MEM:    if (mem_ack) next_state = (opcode == OP_LW) ? ST_WB : done_state;
                 else if (timer_expired) next_state = ST_ERROR;
      ST_WB:     next_state = done_state;
      ST_ERROR:  next_state = ST_ERROR;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    pc_src       = PC_SRC_ALU;
    alu_src_a    = 1'b0;
    alu_src_b    = ALUB_RT;
    alu_op       = ALU_ADD;
    reg_dst      = REG_DST_RT;
    mem_to_reg   = MEM_TO_REG_ALU;
    sign_or_zero = 1'b1;
    retired      = 1'b0;
    err          = 1'b0;
    case (state)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = ALUB_TWO;
        end
      end
      ST_DECODE: alu_src_b = ALUB_IMM_SH;
      ST_EXEC: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FUNCT_JR) begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_RS;
              retired  = 1'b1;
            end else begin
              alu_src_a = 1'b1;
            end
          end
          OP_SLTI: begin
            alu_src_a    = 1'b1;
            alu_src_b    = ALUB_IMM;
            alu_op       = ALU_SLT;
            sign_or_zero = 1'b0;
          end
          OP_LW, OP_SW, OP_ADDI: begin
            alu_src_a = 1'b1;
            alu_src_b = ALUB_IMM;
            alu_op    = ALU_IMM;
          end
          OP_BEQ: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_SUB;
            pc_write  = zero;
            pc_src    = PC_SRC_ALUOUT;
            retired   = 1'b1;
          end
          OP_J: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
            retired  = 1'b1;
          end
          OP_JAL: begin
            pc_write   = 1'b1;
            pc_src     = PC_SRC_JUMP;
            retired    = 1'b1;
            reg_write  = 1'b1;
            reg_dst    = REG_DST_RA;
            mem_to_reg = MEM_TO_REG_PC;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == OP_SW);
        retired = mem_ack && (opcode == OP_SW);
      end
      ST_WB: begin
        reg_write  = 1'b1;
        retired    = 1'b1;
        reg_dst    = (opcode == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
        mem_to_reg = (opcode == OP_LW) ? MEM_TO_REG_MEM : MEM_TO_REG_ALU;
      end
      ST_ERROR: err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips16_mc_control.sv
// Directed bench for mips16_mc_control (ACK_TIMEOUT=4): walks each instruction
// class cycle by cycle and compares every output against hand-derived values.
module tb_mips16_mc_control;

  logic       clk = 1'b0;
  logic       reset, run, zero, mem_ack;
  logic [2:0] opcode;
  logic [3:0] funct;
  logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write;
  logic [1:0] pc_src, alu_src_b, alu_op, reg_dst, mem_to_reg;
  logic       alu_src_a, sign_or_zero, retired, err;

  int n_compared = 0;
  int n_mismatched = 0;

  // Strobe bits: {mem_req, mem_we, iord, ir_write, pc_write, reg_write, retired, err}
  localparam logic [7:0] S_NONE = 8'h00, S_MREQ = 8'h80, S_MWE = 8'h40, S_IORD = 8'h20,
                         S_IRW = 8'h10, S_PCW = 8'h08, S_RW = 8'h04, S_RET = 8'h02, S_ERR = 8'h01;
  // Mux fields: {pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, sign_or_zero}
  localparam logic [11:0] M_DEF   = {2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
  localparam logic [11:0] M_FACK  = {2'b00, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1};
  localparam logic [11:0] M_DEC   = {2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1};
  localparam logic [11:0] M_EXR   = {2'b00, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
  localparam logic [11:0] M_SLTI  = {2'b00, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0};
  localparam logic [11:0] M_IMM   = {2'b00, 1'b1, 2'b10, 2'b11, 2'b00, 2'b00, 1'b1};
  localparam logic [11:0] M_BEQ   = {2'b01, 1'b1, 2'b00, 2'b01, 2'b00, 2'b00, 1'b1};
  localparam logic [11:0] M_J     = {2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
  localparam logic [11:0] M_JAL   = {2'b10, 1'b0, 2'b00, 2'b00, 2'b10, 2'b10, 1'b1};
  localparam logic [11:0] M_JR    = {2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1};
  localparam logic [11:0] M_WBR   = {2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 1'b1};
  localparam logic [11:0] M_WBLW  = {2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1};

  logic [7:0]  strobes;
  logic [11:0] muxes;
  assign strobes = {mem_req, mem_we, iord, ir_write, pc_write, reg_write, retired, err};
  assign muxes   = {pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, sign_or_zero};

  mips16_mc_control #(.ACK_TIMEOUT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .opcode       (opcode),
    .funct        (funct),
    .zero         (zero),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .iord         (iord),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .reg_write    (reg_write),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .sign_or_zero (sign_or_zero),
    .retired      (retired),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [7:0] exp_s, input logic [11:0] exp_m);
    n_compared++;
    assert ({strobes, muxes} === {exp_s, exp_m}) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed strobes=%02h mux=%03h expected strobes=%02h mux=%03h",
             tag, strobes, muxes, exp_s, exp_m);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then check the outputs of that cycle.
  task automatic apply_stimulus(input string tag, input logic r, input logic [2:0] op,
                                input logic [3:0] fn, input logic z, input logic ack,
                                input logic [7:0] exp_s, input logic [11:0] exp_m);
    @(negedge clk);
    run = r; opcode = op; funct = fn; zero = z; mem_ack = ack;
    #1;
    check_output(tag, exp_s, exp_m);
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; opcode = 3'b000; funct = 4'b0000; zero = 1'b0; mem_ack = 1'b0;
    apply_stimulus("reset_hold", 0, 3'b000, 4'h0, 0, 1, S_NONE, M_DEF);
    @(negedge clk); reset = 1'b0;
    apply_stimulus("idle_norun", 0, 3'b000, 4'h0, 0, 1, S_NONE, M_DEF);
    apply_stimulus("idle_run",   1, 3'b000, 4'h0, 0, 0, S_NONE, M_DEF);

    // R-type, zero-wait memory
    apply_stimulus("r_fetch",  1, 3'b000, 4'h0, 0, 1, S_MREQ | S_IRW | S_PCW, M_FACK);
    apply_stimulus("r_decode", 1, 3'b000, 4'h0, 0, 0, S_NONE, M_DEC);
    apply_stimulus("r_exec",   1, 3'b000, 4'h0, 0, 0, S_NONE, M_EXR);
    apply_stimulus("r_wb",     1, 3'b000, 4'h0, 0, 0, S_RW | S_RET, M_WBR);

    // lw with three wait cycles in MEM; ack lands on the timeout threshold cycle
    apply_stimulus("lw_fetch",  1, 3'b100, 4'h0, 0, 1, S_MREQ | S_IRW | S_PCW, M_FACK);
    apply_stimulus("lw_decode", 1, 3'b100, 4'h0, 0, 0, S_NONE, M_DEC);
    apply_stimulus("lw_exec",   1, 3'b100, 4'h0, 0, 0, S_NONE, M_IMM);
    for (int i = 0; i < 3; i++)
      apply_stimulus($sformatf("lw_mem_wait%0d", i), 1, 3'b100, 4'h0, 0, 0, S_MREQ | S_IORD, M_DEF);
    apply_stimulus("lw_mem_ack", 1, 3'b100, 4'h0, 0, 1, S_MREQ | S_IORD, M_DEF);
    apply_stimulus("lw_wb",      1, 3'b100, 4'h0, 0, 0, S_RW | S_RET, M_WBLW);

    // beq taken then not taken
    apply_stimulus("beq1_fetch", 1, 3'b110, 4'h0, 1, 1, S_MREQ | S_IRW | S_PCW, M_FACK);
    apply_stimulus("beq1_dec",   1, 3'b110, 4'h0, 1, 0, S_NONE, M_DEC);
    apply_stimulus("beq1_exec",  1, 3'b110, 4'h0, 1, 0, S_PCW | S_RET, M_BEQ);
    apply_stimulus("beq0_fetch", 1, 3'b110, 4'h0, 0, 1, S_MREQ | S_IRW | S_PCW, M_FACK);
    apply_stimulus("beq0_dec",   1, 3'b110, 4'h0, 0, 0, S_NONE, M_DEC);
    apply_stimulus("beq0_exec",  1, 3'b110, 4'h0, 0, 0, S_RET, M_BEQ);

    // Jumps
    apply_stimulus("j_fetch",   1, 3'b010, 4'h0, 0, 1, S_MREQ | S_IRW | S_PCW, M_FACK);
    apply_stimulus("j_dec",     1, 3'b010, 4'h0, 0, 0, S_NONE, M_DEC);
    apply_stimulus("j_exec",    1, 3'b010, 4'h0, 0, 0, S_PCW | S_RET, M_J);
    apply_stimulus("jal_fetch", 1, 3'b011, 4'h0, 0, 1, S_MREQ | S_IRW | S_PCW, M_FACK);
    apply_stimulus("jal_dec",   1, 3'b011, 4'h0, 0, 0, S_NONE, M_DEC);
    apply_stimulus("jal_exec",  1, 3'b011, 4'h0, 0, 0, S_PCW | S_RW | S_RET, M_JAL);
    apply_stimulus("jr_fetch",  1, 3'b000, 4'h8, 0, 1, S_MREQ | S_IRW | S_PCW, M_FACK);
    apply_stimulus("jr_dec",    1, 3'b000, 4'h8, 0, 0, S_NONE, M_DEC);
    apply_stimulus("jr_exec",   1, 3'b000, 4'h8, 0, 0, S_PCW | S_RET, M_JR);

    // slti and addi write back through rt with the ALU result
    apply_stimulus("slti_fetch", 1, 3'b001, 4'h0, 0, 1, S_MREQ | S_IRW | S_PCW, M_FACK);
    apply_stimulus("slti_dec",   1, 3'b001, 4'h0, 0, 0, S_NONE, M_DEC);
    apply_stimulus("slti_exec",  1, 3'b001, 4'h0, 0, 0, S_NONE, M_SLTI);
    apply_stimulus("slti_wb",    1, 3'b001, 4'h0, 0, 0, S_RW | S_RET, M_DEF);
    apply_stimulus("addi_fetch", 1, 3'b111, 4'h0, 0, 1, S_MREQ | S_IRW | S_PCW, M_FACK);
    apply_stimulus("addi_dec",   1, 3'b111, 4'h0, 0, 0, S_NONE, M_DEC);
    apply_stimulus("addi_exec",  1, 3'b111, 4'h0, 0, 0, S_NONE, M_IMM);
    apply_stimulus("addi_wb",    1, 3'b111, 4'h0, 0, 0, S_RW | S_RET, M_DEF);

    // sw with run dropped during MEM: request held until ack, then IDLE
    apply_stimulus("sw_fetch",    1, 3'b101, 4'h0, 0, 1, S_MREQ | S_IRW | S_PCW, M_FACK);
    apply_stimulus("sw_dec",      1, 3'b101, 4'h0, 0, 0, S_NONE, M_DEC);
    apply_stimulus("sw_exec",     1, 3'b101, 4'h0, 0, 0, S_NONE, M_IMM);
    apply_stimulus("sw_mem_wait", 0, 3'b101, 4'h0, 0, 0, S_MREQ | S_MWE | S_IORD, M_DEF);
    apply_stimulus("sw_mem_ack",  0, 3'b101, 4'h0, 0, 1, S_MREQ | S_MWE | S_IORD | S_RET, M_DEF);
    apply_stimulus("sw_idle0",    0, 3'b101, 4'h0, 0, 1, S_NONE, M_DEF);
    apply_stimulus("sw_idle1",    1, 3'b101, 4'h0, 0, 0, S_NONE, M_DEF);

    // Fetch ack arrives on the 4th wait cycle: no error
    for (int i = 0; i < 3; i++)
      apply_stimulus($sformatf("late_fetch_wait%0d", i), 1, 3'b010, 4'h0, 0, 0, S_MREQ, M_DEF);
    apply_stimulus("late_fetch_ack", 0, 3'b010, 4'h0, 0, 1, S_MREQ | S_IRW | S_PCW, M_FACK);
    apply_stimulus("late_dec",       0, 3'b010, 4'h0, 0, 0, S_NONE, M_DEC);
    apply_stimulus("late_exec",      0, 3'b010, 4'h0, 0, 0, S_PCW | S_RET, M_J);
    apply_stimulus("late_idle",      1, 3'b010, 4'h0, 0, 0, S_NONE, M_DEF);

    // No ack at all: ERROR after 4 wait cycles, sticky
    for (int i = 0; i < 4; i++)
      apply_stimulus($sformatf("to_fetch_wait%0d", i), 1, 3'b000, 4'h0, 0, 0, S_MREQ, M_DEF);
    apply_stimulus("to_err0", 1, 3'b000, 4'h0, 0, 1, S_ERR, M_DEF);
    apply_stimulus("to_err1", 1, 3'b000, 4'h0, 0, 0, S_ERR, M_DEF);

    // Reset clears the error, then an asynchronous reset in DECODE
    @(negedge clk); reset = 1'b1;
    apply_stimulus("err_cleared", 0, 3'b000, 4'h0, 0, 0, S_NONE, M_DEF);
    @(negedge clk); reset = 1'b0;
    apply_stimulus("rst_idle_run", 1, 3'b111, 4'h0, 0, 0, S_NONE, M_DEF);
    apply_stimulus("rst_fetch",    1, 3'b111, 4'h0, 0, 1, S_MREQ | S_IRW | S_PCW, M_FACK);
    apply_stimulus("rst_decode",   1, 3'b111, 4'h0, 0, 0, S_NONE, M_DEC);
    #2 reset = 1'b1;
    #1 check_output("async_reset", S_NONE, M_DEF);
    apply_stimulus("reset_held", 1, 3'b111, 4'h0, 0, 1, S_NONE, M_DEF);
    @(negedge clk); run = 1'b0; reset = 1'b0;
    apply_stimulus("post_rst_idle", 0, 3'b111, 4'h0, 0, 1, S_NONE, M_DEF);
    apply_stimulus("post_rst_run",  1, 3'b111, 4'h0, 0, 0, S_NONE, M_DEF);
    apply_stimulus("post_rst_fetch", 1, 3'b111, 4'h0, 0, 1, S_MREQ | S_IRW | S_PCW, M_FACK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
